lockstep_periph_master: RTL and testbench

Initiator (master) end of the cluster peripheral-crossbar request/response protocol. It turns a simple valid/ready command stream into single-outstanding peripheral-bus transactions and returns read data and error status on a valid/ready response stream. It sits between a cluster-local sequencer (debug/boot/test controller) and the peripheral crossbar. It is used to program and poll the lockstep controller and any other cluster peripheral.

---
 rtl/lockstep_periph_master_pkg.sv | 66 ++++++
 rtl/lockstep_periph_master_if.sv | 70 +++++++
 rtl/lockstep_periph_timeout_ctr.sv | 61 ++++++
 rtl/lockstep_periph_master.sv | 169 ++++++++++++++++
 tb/tb_lockstep_periph_master.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lockstep_periph_master_pkg.sv
// ---------------------------------------------------------------------------
// lockstep_periph_pkg
//
// Shared types for the peripheral-crossbar initiator.
//
// Contents:
//   PKG_ADDR_WIDTH / PKG_DATA_WIDTH / PKG_BE_WIDTH
//       Storage widths of the command and response records. The master's
//       ADDR_WIDTH / DATA_WIDTH parameters default to these values.
//   OPC_ERR   response opcode value that flags an error
//   state_e   transaction FSM states
//   cmd_t     latched command (address, direction, write data, byte enables)
//   rsp_t     latched response (read data, error, timeout flag)
//   captureRsp / timeoutRsp
//       Build the response record handed back to the sequencer.
// ---------------------------------------------------------------------------
package lockstep_periph_pkg;

    localparam int unsigned PKG_ADDR_WIDTH = 32;
    localparam int unsigned PKG_DATA_WIDTH = 32;
    localparam int unsigned PKG_BE_WIDTH   = PKG_DATA_WIDTH / 8;

    localparam logic OPC_ERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RSP    = 2'd3
    } state_e;

    typedef struct packed {
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [PKG_DATA_WIDTH-1:0] wdata;
        logic [PKG_BE_WIDTH-1:0]   be;
    } cmd_t;

    typedef struct packed {
        logic [PKG_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } rsp_t;

    // Read data is only meaningful for a successful read, so writes and
    // error responses report zero data to the sequencer.
    function automatic rsp_t captureRsp(input logic                      isWrite,
                                        input logic                      opc,
                                        input logic [PKG_DATA_WIDTH-1:0] rdata);
        rsp_t rsp;
        rsp.err     = (opc == OPC_ERR);
        rsp.timeout = 1'b0;
        rsp.rdata   = (isWrite || rsp.err) ? '0 : rdata;
        return rsp;
    endfunction

    // A transaction abandoned by the watchdog: error plus timeout, no data.
    function automatic rsp_t timeoutRsp();
        rsp_t rsp;
        rsp.rdata   = '0;
        rsp.err     = 1'b1;
        rsp.timeout = 1'b1;
        return rsp;
    endfunction

endpackage

// File: rtl/lockstep_periph_master_if.sv
// ---------------------------------------------------------------------------
// lockstep_periph_master_if
//
// Bundles the three streams the initiator talks on. Signal suffixes are
// written from the master's point of view.
//
//   Command stream (sequencer -> master):
//     cmd_valid_i, cmd_ready_o, cmd_addr_i, cmd_we_i, cmd_wdata_i, cmd_be_i
//   Response stream (master -> sequencer):
//     rsp_valid_o, rsp_ready_i, rsp_rdata_o, rsp_err_o, rsp_timeout_o
//   Peripheral bus (master <-> crossbar):
//     req_o, add_o, wen_o (active-low write), wdata_o, be_o, id_o, gnt_i,
//     r_valid_i, r_opc_i, r_id_i, r_rdata_i
//
// Modports:
//   master  the initiator itself
//   slave   everything around it (sequencer plus crossbar)
// ---------------------------------------------------------------------------
interface lockstep_periph_master_if #(
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic                  cmd_we_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [BE_WIDTH-1:0]   cmd_be_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic                  req_o;
    logic [ADDR_WIDTH-1:0] add_o;
    logic                  wen_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [BE_WIDTH-1:0]   be_o;
    logic [ID_WIDTH-1:0]   id_o;
    logic                  gnt_i;
    logic                  r_valid_i;
    logic                  r_opc_i;
    logic [ID_WIDTH-1:0]   r_id_i;
    logic [DATA_WIDTH-1:0] r_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_wdata_i, cmd_be_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output req_o, add_o, wen_o, wdata_o, be_o, id_o,
        input  gnt_i, r_valid_i, r_opc_i, r_id_i, r_rdata_i
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_wdata_i, cmd_be_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  req_o, add_o, wen_o, wdata_o, be_o, id_o,
        output gnt_i, r_valid_i, r_opc_i, r_id_i, r_rdata_i
    );

endinterface

// File: rtl/lockstep_periph_timeout_ctr.sv
// ---------------------------------------------------------------------------
// lockstep_periph_timeout_ctr
//
// Watchdog for the response wait. Counts enabled cycles since the last
// clear and flags the last permitted cycle.
//
// Ports:
//   clk_i     clock
//   rst_ni    synchronous active-low reset (count returns to 0)
//   clear_i   forces the count back to 0 (has priority over enable_i)
//   enable_i  advance the count by one this cycle
//   tc_o      count has reached TIMEOUT_CYCLES-1; constant 0 when
//             TIMEOUT_CYCLES is 0 (watchdog disabled)
// ---------------------------------------------------------------------------
module lockstep_periph_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] TC_VALUE =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise step while enabled. The count parks
    // at the terminal value so it can never wrap back into the window and
    // miss the timeout if the owner keeps it enabled for longer.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != TC_VALUE)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // With the watchdog disabled the terminal count must never fire, even
    // though the counter register still exists.
    if (TIMEOUT_CYCLES == 0) begin : gNoTimeout
        assign tc_o = 1'b0;
    end else begin : gTimeout
        assign tc_o = (count_q == TC_VALUE);
    end

endmodule

// File: rtl/lockstep_periph_master.sv
// ---------------------------------------------------------------------------
// lockstep_periph_master
//
// Initiator end of the cluster peripheral-crossbar protocol. Converts a
// valid/ready command stream into single-outstanding bus transactions and
// returns read data / error status on a valid/ready response stream.
//
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   bus      lockstep_periph_master_if.master
//              command stream : cmd_valid_i/cmd_ready_o, cmd_addr_i,
//                               cmd_we_i, cmd_wdata_i, cmd_be_i
//              response stream: rsp_valid_o/rsp_ready_i, rsp_rdata_o,
//                               rsp_err_o, rsp_timeout_o
//              peripheral bus : req_o, add_o, wen_o (0 = write), wdata_o,
//                               be_o, id_o (= MASTER_ID), gnt_i, r_valid_i,
//                               r_opc_i (1 = error), r_id_i, r_rdata_i
//
// Flow: IDLE accepts a command, REQ holds the request until granted,
// WAIT_R waits (under watchdog) for a response carrying our ID, RSP holds
// the result until the sequencer takes it. A response arriving together
// with the grant skips WAIT_R.
// ---------------------------------------------------------------------------
module lockstep_periph_master
    import lockstep_periph_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned MASTER_ID      = 0,
    parameter int unsigned ADDR_WIDTH     = PKG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = PKG_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    lockstep_periph_master_if.master bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ID_WIDTH-1:0] OWN_ID = ID_WIDTH'(MASTER_ID);

    state_e state_q;
    state_e state_d;
    logic   req_q;
    logic   req_d;
    cmd_t   cmd_q;
    cmd_t   cmd_d;
    rsp_t   rsp_q;
    rsp_t   rsp_d;

    logic   rspMatch;
    logic   cntClear;
    logic   cntEnable;
    logic   timeoutTc;

    // Responses tagged for other initiators share the return path and must
    // be ignored entirely.
    assign rspMatch = bus.r_valid_i && (bus.r_id_i == OWN_ID);

    lockstep_periph_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .tc_o     (timeoutTc)
    );

    // Next-state and datapath decisions. The watchdog only runs in WAIT_R
    // and is held clear everywhere else, so every wait starts from zero.
    // A matching response on the last watchdog cycle still wins over the
    // timeout. Responses seen in IDLE or RSP fall through the default and
    // are dropped, which covers late replies to a timed-out transaction.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cmd_d     = cmd_q;
        rsp_d     = rsp_q;
        cntClear  = 1'b1;
        cntEnable = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    cmd_d.addr  = PKG_ADDR_WIDTH'(bus.cmd_addr_i);
                    cmd_d.we    = bus.cmd_we_i;
                    cmd_d.wdata = PKG_DATA_WIDTH'(bus.cmd_wdata_i);
                    cmd_d.be    = PKG_BE_WIDTH'(bus.cmd_be_i);
                    req_d       = 1'b1;
                    state_d     = REQ;
                end
            end

            REQ: begin
                if (bus.gnt_i) begin
                    req_d = 1'b0;
                    if (rspMatch) begin
                        rsp_d   = captureRsp(cmd_q.we, bus.r_opc_i,
                                             PKG_DATA_WIDTH'(bus.r_rdata_i));
                        state_d = RSP;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end

            WAIT_R: begin
                cntClear  = 1'b0;
                cntEnable = 1'b1;
                if (rspMatch) begin
                    rsp_d   = captureRsp(cmd_q.we, bus.r_opc_i,
                                         PKG_DATA_WIDTH'(bus.r_rdata_i));
                    state_d = RSP;
                end else if (timeoutTc) begin
                    rsp_d   = timeoutRsp();
                    state_d = RSP;
                end
            end

            RSP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, bus-side request/command and captured response all live in
    // flops so the bus outputs come straight from registers. Reset clears
    // the latched command, which leaves wen_o at 1 (read) and drops req_o
    // on the reset edge even mid-transaction.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cmd_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            rsp_q   <= rsp_d;
        end
    end

    // Only one transaction may be outstanding, so commands are accepted
    // exclusively in IDLE and the response is presented only in RSP.
    assign bus.cmd_ready_o   = (state_q == IDLE);
    assign bus.rsp_valid_o   = (state_q == RSP);
    assign bus.rsp_rdata_o   = DATA_WIDTH'(rsp_q.rdata);
    assign bus.rsp_err_o     = rsp_q.err;
    assign bus.rsp_timeout_o = rsp_q.timeout;

    // The bus write-enable is active-low, hence the inversion of the
    // stored direction bit.
    assign bus.req_o   = req_q;
    assign bus.add_o   = ADDR_WIDTH'(cmd_q.addr);
    assign bus.wen_o   = ~cmd_q.we;
    assign bus.wdata_o = DATA_WIDTH'(cmd_q.wdata);
    assign bus.be_o    = BE_WIDTH'(cmd_q.be);
    assign bus.id_o    = OWN_ID;

endmodule

// File: tb/tb_lockstep_periph_master.sv
// ---------------------------------------------------------------------------
// tb_lockstep_periph_master
//
// Directed and randomized transactions against lockstep_periph_master.
// Each transaction's expected outcome (request duration, wait length,
// response data/error/timeout) is derived from the protocol rules.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lockstep_periph_master;

    localparam int unsigned ID_WIDTH       = 2;
    localparam int unsigned MASTER_ID      = 2;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam logic [ID_WIDTH-1:0] OWN_ID   = ID_WIDTH'(MASTER_ID);
    localparam logic [ID_WIDTH-1:0] OTHER_ID = OWN_ID ^ ID_WIDTH'(1);
    localparam int WAIT_BUDGET = 64;

    logic clk;
    logic rst_n;
    int   testCount;
    int   failCount;

    lockstep_periph_master_if #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) bus ();

    lockstep_periph_master #(
        .ID_WIDTH       (ID_WIDTH),
        .MASTER_ID      (MASTER_ID),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one complete transaction. gntDelay = idle cycles before the
    // grant; rspDelay = cycle after the grant on which the matching reply
    // is driven (0 = together with the grant); badId = drive replies for
    // another ID on every other waiting cycle; noRsp = never reply;
    // readyDelay = cycles the response is left unconsumed.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int gntDelay, input int rspDelay,
                                 input logic [31:0] rdata, input logic opc,
                                 input logic badId, input logic noRsp,
                                 input int readyDelay);
        logic        timedOut;
        logic [31:0] expRdata;
        logic        expErr;
        int          expWait;
        int          stableCycles;
        int          waitCycles;

        timedOut = noRsp || (rspDelay > int'(TIMEOUT_CYCLES));
        expWait  = timedOut ? int'(TIMEOUT_CYCLES) : rspDelay;
        expRdata = (timedOut || we || opc) ? 32'h0 : rdata;
        expErr   = timedOut || opc;

        checkOutput("cmdReadyIdle", {63'h0, bus.cmd_ready_o}, 64'h1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wdata;
        bus.cmd_be_i    = be;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = $urandom;
        bus.cmd_we_i    = ~we;
        bus.cmd_wdata_i = $urandom;
        bus.cmd_be_i    = 4'($urandom);

        stableCycles = 0;
        for (int k = 0; k <= gntDelay; k++) begin
            if (bus.req_o === 1'b1 && bus.add_o === addr && bus.wen_o === ~we &&
                bus.wdata_o === wdata && bus.be_o === be &&
                bus.cmd_ready_o === 1'b0 && bus.id_o === OWN_ID)
                stableCycles++;
            if (k == gntDelay) begin
                bus.gnt_i = 1'b1;
                if (!noRsp && rspDelay == 0) begin
                    bus.r_valid_i = 1'b1;
                    bus.r_id_i    = OWN_ID;
                    bus.r_opc_i   = opc;
                    bus.r_rdata_i = rdata;
                end
            end
            @(negedge clk);
            bus.gnt_i     = 1'b0;
            bus.r_valid_i = 1'b0;
        end
        checkOutput("reqStable", 64'(stableCycles), 64'(gntDelay + 1));
        checkOutput("reqDrop", {63'h0, bus.req_o}, 64'h0);

        waitCycles = 0;
        while (bus.rsp_valid_o !== 1'b1 && waitCycles < WAIT_BUDGET) begin
            if (!noRsp && (waitCycles + 1) == rspDelay) begin
                bus.r_valid_i = 1'b1;
                bus.r_id_i    = OWN_ID;
                bus.r_opc_i   = opc;
                bus.r_rdata_i = rdata;
            end else if (badId) begin
                bus.r_valid_i = 1'b1;
                bus.r_id_i    = OTHER_ID;
                bus.r_opc_i   = 1'b0;
                bus.r_rdata_i = $urandom;
            end
            @(negedge clk);
            bus.r_valid_i = 1'b0;
            waitCycles++;
        end
        checkOutput("waitCycles", 64'(waitCycles), 64'(expWait));

        checkOutput("rspValid", {63'h0, bus.rsp_valid_o}, 64'h1);
        checkOutput("rspRdata", {32'h0, bus.rsp_rdata_o}, {32'h0, expRdata});
        checkOutput("rspErrTo", {62'h0, bus.rsp_err_o, bus.rsp_timeout_o},
                    {62'h0, expErr, timedOut});
        checkOutput("reqInRsp", {62'h0, bus.req_o, bus.cmd_ready_o}, 64'h0);

        for (int i = 0; i < readyDelay; i++) begin
            bus.r_valid_i   = 1'b1;
            bus.r_id_i      = OWN_ID;
            bus.r_opc_i     = 1'($urandom);
            bus.r_rdata_i   = $urandom;
            bus.cmd_valid_i = 1'b1;
            @(negedge clk);
        end
        bus.r_valid_i   = 1'b0;
        bus.cmd_valid_i = 1'b0;
        if (readyDelay > 0) begin
            checkOutput("rspHeld",
                        {29'h0, bus.rsp_valid_o, bus.cmd_ready_o, bus.rsp_err_o,
                         bus.rsp_timeout_o, bus.rsp_rdata_o},
                        {29'h0, 1'b1, 1'b0, expErr, timedOut, expRdata});
        end

        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        checkOutput("rspDone", {62'h0, bus.rsp_valid_o, bus.cmd_ready_o}, 64'h1);

        bus.r_valid_i = 1'b1;
        bus.r_id_i    = OWN_ID;
        bus.r_rdata_i = $urandom;
        @(negedge clk);
        bus.r_valid_i = 1'b0;
        checkOutput("strayIdle", {61'h0, bus.rsp_valid_o, bus.req_o, bus.cmd_ready_o}, 64'h1);
    endtask

    initial begin
        testCount       = 0;
        failCount       = 0;
        rst_n           = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_wdata_i = '0;
        bus.cmd_be_i    = '0;
        bus.rsp_ready_i = 1'b0;
        bus.gnt_i       = 1'b0;
        bus.r_valid_i   = 1'b0;
        bus.r_opc_i     = 1'b0;
        bus.r_id_i      = OWN_ID;
        bus.r_rdata_i   = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("resetBusCtl", {60'h0, bus.req_o, bus.wen_o, bus.cmd_ready_o, bus.rsp_valid_o},
                    64'h6);
        checkOutput("resetId", {62'h0, bus.id_o}, {62'h0, OWN_ID});
        checkOutput("resetRsp", {30'h0, bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_rdata_o}, 64'h0);
        checkOutput("resetAddr", {32'h0, bus.add_o}, 64'h0);

        // Write, granted at once, reply one cycle after the grant.
        applyStimulus(1'b1, 32'h1020_0000, 32'h0000_00A5, 4'hF, 0, 1, 32'h1234_5678,
                      1'b0, 1'b0, 1'b0, 0);
        // Read with a three-cycle grant delay.
        applyStimulus(1'b0, 32'h1020_0004, 32'h0, 4'hF, 3, 1, 32'hDEAD_BEEF,
                      1'b0, 1'b0, 1'b0, 0);
        // Read whose reply coincides with the grant.
        applyStimulus(1'b0, 32'h1020_0008, 32'h0, 4'hF, 1, 0, 32'hCAFE_F00D,
                      1'b0, 1'b0, 1'b0, 0);
        // Foreign-ID replies ignored, then an error reply.
        applyStimulus(1'b0, 32'h1020_000C, 32'h0, 4'h3, 0, 3, 32'h5555_AAAA,
                      1'b1, 1'b1, 1'b0, 0);
        // No reply: watchdog fires, late replies dropped while unconsumed.
        applyStimulus(1'b0, 32'h1020_0010, 32'h0, 4'hF, 0, 0, 32'h0,
                      1'b0, 1'b0, 1'b1, 3);
        // Next command after the timeout proceeds normally.
        applyStimulus(1'b0, 32'h1020_0014, 32'h0, 4'hF, 2, 2, 32'h0BAD_CAFE,
                      1'b0, 1'b0, 1'b0, 0);
        // Response left unconsumed for five cycles.
        applyStimulus(1'b1, 32'h1020_0018, 32'h7777_0001, 4'hC, 1, 4, 32'hFFFF_FFFF,
                      1'b0, 1'b0, 1'b0, 5);

        // Reset while a new write request is pending.
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_addr_i  = 32'h1020_001C;
        bus.cmd_wdata_i = 32'h0000_0042;
        bus.cmd_be_i    = 4'hF;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        checkOutput("reqBeforeReset", {62'h0, bus.req_o, bus.wen_o}, 64'h2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("resetMidTxn", {60'h0, bus.req_o, bus.wen_o, bus.cmd_ready_o, bus.rsp_valid_o},
                    64'h6);
        bus.r_valid_i = 1'b1;
        bus.r_id_i    = OWN_ID;
        bus.r_rdata_i = 32'h1357_9BDF;
        @(negedge clk);
        bus.r_valid_i = 1'b0;
        checkOutput("pendingDropped", {61'h0, bus.rsp_valid_o, bus.req_o, bus.cmd_ready_o}, 64'h1);

        // Randomized traffic, including natural timeouts (rspDelay > 8).
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 10)), $urandom,
                          ($urandom_range(0, 3) == 0), 1'($urandom),
                          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
